pool_relu: RTL and testbench

POOL_RELU -- requirements
Module: pool_relu

---
 rtl/pool_relu.sv | 119 +++++++++++
 tb/tb_pool_relu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pool_relu.sv
// pool_relu: 2x2 max pooling over a 4x4 frame of signed 20-bit samples.
// The 16 samples arrive in raster order. Each completed 2x2 window produces
// one pooled result one clock after its last sample. That happens at sample
// indices 5, 7, 13 and 15. pool_finish accompanies the fourth result.
// Optional feature: define POOL_RELU_EN to clamp every accepted sample to
// max(sample, 0) before pooling. Timing and ports do not change.
module pool_relu (
  input  logic               clk,
  input  logic               rst,
  input  logic               pool_start,
  input  logic               pool_ivalid,
  input  logic signed [19:0] pool_idata,
  output logic               pool_ovalid,
  output logic signed [19:0] pool_odata,
  output logic               pool_finish,
  output logic               pool_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_cnt;
  logic signed [19:0] r_prev;
  logic signed [19:0] r_buf [0:1];
  logic               r_ovalid;
  logic signed [19:0] r_odata;
  logic               r_finish;

  logic               w_accept;
  logic signed [19:0] w_sample;
  logic [1:0]         w_col;
  logic               w_row_odd;
  logic signed [19:0] w_pair;
  logic signed [19:0] w_buf_sel;
  logic signed [19:0] w_pool;

  // A sample counts only while collecting. A start pulse in the same cycle
  // restarts the frame, so that sample is dropped.
  assign w_accept  = (r_state == COLLECT) && pool_ivalid && !pool_start;

`ifdef POOL_RELU_EN
  assign w_sample  = pool_idata[19] ? 20'sd0 : pool_idata;
`else
  assign w_sample  = pool_idata;
`endif

  assign w_col     = r_cnt[1:0];
  assign w_row_odd = r_cnt[2];
  assign w_pair    = (r_prev > w_sample) ? r_prev : w_sample;
  assign w_buf_sel = r_buf[w_col[1]];
  assign w_pool    = (w_buf_sel > w_pair) ? w_buf_sel : w_pair;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic. A start pulse in any state arms a fresh frame.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (pool_start) w_state_next = COLLECT;
      COLLECT: begin
        if (pool_start)                        w_state_next = COLLECT;
        else if (pool_ivalid && r_cnt == 4'd15) w_state_next = DONE;
      end
      DONE:    w_state_next = pool_start ? COLLECT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Sample counter and the left sample of the current horizontal pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 4'd0;
      r_prev <= 20'sd0;
    end else if (pool_start) begin
      r_cnt  <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 4'd1;
      if (!w_col[0]) r_prev <= w_sample;
    end
  end

  // Row buffer: on even rows it holds the pair maxima for the odd row below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || pool_start) begin
      r_buf[0] <= 20'sd0;
      r_buf[1] <= 20'sd0;
    end else if (w_accept && w_col[0] && !w_row_odd) begin
      r_buf[w_col[1]] <= w_pair;
    end
  end

  // Output register. The strobes last one cycle and the data holds between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovalid <= 1'b0;
      r_finish <= 1'b0;
      r_odata  <= 20'sd0;
    end else begin
      r_ovalid <= w_accept && w_col[0] && w_row_odd;
      r_finish <= w_accept && (r_cnt == 4'd15);
      if (w_accept && w_col[0] && w_row_odd) r_odata <= w_pool;
    end
  end

  assign pool_ovalid = r_ovalid;
  assign pool_odata  = r_odata;
  assign pool_finish = r_finish;
  assign pool_busy   = (r_state == COLLECT);

endmodule

// File: tb/tb_pool_relu.sv
// tb_pool_relu: randomized and directed stimulus for pool_relu.
// The reference model keeps the frame in an array. When a 2x2 window
// completes, the model takes the maximum of its four entries.
module tb_pool_relu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pool_start = 1'b0;
  logic        pool_ivalid = 1'b0;
  logic [19:0] pool_idata = 20'd0;
  logic        pool_ovalid;
  logic [19:0] pool_odata;
  logic        pool_finish;
  logic        pool_busy;

  pool_relu dut (
    .clk        (clk),
    .rst        (rst),
    .pool_start (pool_start),
    .pool_ivalid(pool_ivalid),
    .pool_idata (pool_idata),
    .pool_ovalid(pool_ovalid),
    .pool_odata (pool_odata),
    .pool_finish(pool_finish),
    .pool_busy  (pool_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit fin;
    int at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   frame[16];
  int   mcnt = 0;
  bit   armed = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int relu(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Drive one cycle of inputs and update the reference model.
  task automatic drive(input bit st, input bit iv, input int val);
    int row, col, m, idx;
    exp_t x;
    @(negedge clk);
    pool_start  = st;
    pool_ivalid = iv;
    pool_idata  = val[19:0];
    if (st) begin
      armed = 1'b1;
      mcnt  = 0;
    end else if (iv && armed) begin
      frame[mcnt] = relu(val);
      row = mcnt / 4;
      col = mcnt % 4;
      if ((row % 2 == 1) && (col % 2 == 1)) begin
        m = frame[(row - 1) * 4 + (col - 1)];
        for (int a = 0; a < 2; a++)
          for (int b = 0; b < 2; b++) begin
            idx = (row - 1 + a) * 4 + (col - 1 + b);
            if (frame[idx] > m) m = frame[idx];
          end
        x.val = m;
        x.fin = (mcnt == 15);
        x.at  = cyc + 1;
        q.push_back(x);
        $display("sample n=%0d -> expect pooled %0d at cycle %0d", mcnt, m, x.at);
      end
      mcnt++;
      if (mcnt == 16) armed = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, int'($urandom));
  endtask

  task automatic send(input int val, input int gap);
    drive(1'b0, 1'b1, val);
    idle(gap);
  endtask

  task automatic ramp(input int base, input int step, input int gap);
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 16; i++) send(base + i * step, gap);
  endtask

  function automatic int rand_val();
    logic [19:0] r;
    case ($urandom_range(0, 5))
      0:       r = 20'h80000;
      1:       r = 20'h7ffff;
      default: r = 20'($urandom);
    endcase
    return int'($signed(r));
  endfunction

  // Output monitor, sampled 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (!rst) begin
      check("busy", int'(pool_busy), int'(armed));
      if (pool_ovalid) begin
        if (q.size() == 0) begin
          check("spurious_ovalid", 1, 0);
        end else begin
          e = q.pop_front();
          $display("output %0d finish=%0d at cycle %0d", $signed(pool_odata), pool_finish, cyc);
          check("odata", int'($signed(pool_odata)), e.val);
          check("finish", int'(pool_finish), int'(e.fin));
          check("latency", cyc, e.at);
        end
      end else begin
        check("finish_no_ovalid", int'(pool_finish), 0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ovalid"}, int'(pool_ovalid), 0);
    check({tag, "_odata"},  int'(pool_odata), 0);
    check({tag, "_finish"}, int'(pool_finish), 0);
    check({tag, "_busy"},   int'(pool_busy), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Ramp 1..16 back to back.
    ramp(1, 1, 0);
    idle(3);
    // Negative ramp -1..-16.
    ramp(-1, -1, 0);
    idle(3);
    // Ramp with three idle cycles between samples.
    ramp(1, 1, 3);
    idle(3);
    // Abort after nine samples, then a full ramp 101..116.
    drive(1'b1, 1'b0, 0);
    for (int i = 1; i <= 9; i++) send(i, 0);
    ramp(101, 1, 0);
    idle(3);

    // Asynchronous reset after sample 6.
    drive(1'b1, 1'b0, 0);
    for (int i = 1; i <= 6; i++) send(i, 0);
    @(negedge clk);
    pool_ivalid = 1'b0;
    rst = 1'b1;
    #1 check_reset_outputs("midframe_reset");
    armed = 1'b0;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send(i + 50, 0);
    ramp(1, 1, 0);
    idle(3);

    // Start and a sample in the same IDLE cycle: the sample is discarded.
    drive(1'b1, 1'b1, 999);
    for (int i = 1; i <= 16; i++) send(i, 0);
    // Start while in DONE: the next frame begins at once.
    ramp(201, 3, 0);
    idle(3);

    // Random frames with gaps, idle noise, occasional aborts and back-to-back starts.
    for (int f = 0; f < 12; f++) begin
      drive(1'b1, 1'b0, 0);
      if ($urandom_range(0, 3) == 0) begin
        int k = $urandom_range(1, 15);
        for (int i = 0; i < k; i++) send(rand_val(), $urandom_range(0, 2));
        drive(1'b1, 1'b0, 0);
      end
      for (int i = 0; i < 16; i++) send(rand_val(), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 3; i++) send(rand_val(), 0);
        idle($urandom_range(0, 3));
      end
    end

    idle(4);
    check("pending_outputs", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
